lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised last-in/first-out stack that succeeds the fixed 8-bit LIFO. It adds configurable width and depth, a simultaneous push+pop ("swap") mode with empty-stack bypass, an occupancy count, almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a producer that pushes words and a consumer that pops them, both in one clock domain.

## Interface
- DATA_WIDTH, default 8: bits per stored word.
- DEPTH, default 16: number of entries; must be ≥ 2, and need not be a power of two.
- ALMOST_FULL, default DEPTH-2: `almost_full` asserts when count ≥ this value.
- ALMOST_EMPTY, default 2: `almost_empty` asserts when count ≤ this value.
- CNT_W, derived as $clog2(DEPTH+1): width of `count`.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- write_en  in  1  push request.
- read_en  in  1  pop request.
- data_in  in  DATA_WIDTH  word to push.
- err_clr  in  1  synchronous clear of the sticky error flags.
- data_out  out  DATA_WIDTH  registered popped word.
- data_valid  out  1  `data_out` was updated by an accepted pop this cycle.
- top  out  DATA_WIDTH  combinational peek of the top entry; 0 when empty.
- count  out  CNT_W  number of stored entries.
- full / empty  out  1  full is count==DEPTH; empty is count==0.
- almost_full / almost_empty  out  1  threshold flags, decoded from `count`.
- overflow / underflow  out  1  sticky error flags.

## Operation
- Storage is mem[0..DEPTH-1]. The top of the stack is mem[count-1]. Memory contents are not reset.
- The operation is decoded from {write_en, read_en}:
  - NOP (00): no state change; data_valid=0.
  - PUSH (10), not full: mem[count] ← data_in; count+1.
  - PUSH (10), full: the word is dropped, count is unchanged, overflow←1.
  - POP (01), not empty: data_out ← mem[count-1]; count-1; data_valid=1.
  - POP (01), empty: data_out holds its value, data_valid=0, underflow←1.
  - SWAP (11), not empty: data_out ← mem[count-1]; mem[count-1] ← data_in; count is unchanged; data_valid=1. This is legal when full, with no overflow.
  - SWAP (11), empty: bypass, so data_out ← data_in and data_valid=1. count stays 0 and no flag is set.
- Error flags:
  - err_clr=1 clears overflow and underflow.
  - If a new error occurs in the same cycle as err_clr, the set wins.
- Reset, asynchronous: count=0, data_out=0, data_valid=0, overflow=0, underflow=0. As a result, empty=1, full=0, almost_empty=1, almost_full=0 (ALMOST_FULL>0), and top=0.
- Reset mid-operation discards all entries. The first pop after reset reports underflow.

## Timing
- Push to visibility: the pushed word appears on `top`, and count/flags update, in the cycle after the write edge.
- Pop latency is 1 cycle: data_out and data_valid are registered at the accepting edge. data_valid is a single-cycle pulse per accepted pop, and back-to-back pops give one word per cycle.
- full, empty, almost_* and top are combinational from the count register and memory. They are not a function of the current write_en/read_en.
- There is no ready/valid back-pressure. Callers gate requests on full/empty; illegal requests only raise the sticky flags.
- count never leaves the range [0, DEPTH], and never wraps.

## Structure
- Package `lifo_pkg`: the operation encoding localparams OP_NOP, OP_POP, OP_PUSH, OP_SWAP (2-bit {write_en, read_en}), plus the CNT_W derivation helper.
- Sub-module `lifo_mem`: a DEPTH×DATA_WIDTH register array with one synchronous write port and one asynchronous read port (address = count-1). It has no reset.
- The top level holds the count register, the op decode, the data_out/data_valid registers, the flag logic, and parameter sanity checks (DEPTH≥2, ALMOST_EMPTY<ALMOST_FULL≤DEPTH) as elaboration-time errors.

## Test plan
- **Reset:** assert rst mid-cycle with 3 entries stored → count=0, empty=1, data_out=0 immediately. The next pop gives underflow=1 and data_valid=0.
- **LIFO order:** with DEPTH=16, push 35,30,25,20,15,10,5 and then pop 7 times → data_out = 5,10,15,20,25,30,35 on consecutive cycles with data_valid=1 each. Afterwards empty=1 and count=0.
- **Fill and overflow:** push 16 words (0x01..0x10) → full=1 and almost_full set from count=14. A 17th push of 0xFF gives overflow=1, count=16, and top=0x10.
- **Swap when full:** on a full stack with top=0x10, swap in 0xAA → data_out=0x10, data_valid=1, top=0xAA, count=16, and overflow unchanged.
- **Empty bypass:** on an empty stack, swap with data_in=0x5A → data_out=0x5A next cycle, data_valid=1, count=0, underflow=0.
- **Error clear:** with overflow=1, assert err_clr alone → overflow=0. Assert err_clr together with a push to a full stack → overflow stays 1.

Source files
------------

// File: rtl/lifo_pkg.sv
// lifo_pkg: operation encoding and count-width helper for lifo_stack
package lifo_pkg;
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: register array with one synchronous write port and one asynchronous read port
module lifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [AW-1:0]         raddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // the empty-stack address wraps to all ones, which can lie past DEPTH
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with swap/bypass, occupancy count, thresholds and sticky error flags
module lifo_stack import lifo_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ALMOST_FULL = DEPTH - 2,
  parameter int ALMOST_EMPTY = 2,
  parameter int CNT_W = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int AW = $clog2(DEPTH);
  if (DEPTH < 2) begin : g_bad_depth
    $error("lifo_stack: DEPTH must be >= 2");
  end
  if (!(ALMOST_EMPTY < ALMOST_FULL && ALMOST_FULL <= DEPTH)) begin : g_bad_thr
    $error("lifo_stack: need ALMOST_EMPTY < ALMOST_FULL <= DEPTH");
  end
  logic [1:0] op;
  logic do_push, do_pop, do_swap, bypass, ovf_set, unf_set;
  logic [AW-1:0] top_addr;
  logic [DATA_WIDTH-1:0] rd;
  assign op       = {write_en, read_en};
  assign do_push  = op == OP_PUSH && !full;
  assign do_pop   = op == OP_POP && !empty;
  assign do_swap  = op == OP_SWAP && !empty;
  assign bypass   = op == OP_SWAP && empty;
  assign ovf_set  = op == OP_PUSH && full;
  assign unf_set  = op == OP_POP && empty;
  assign top_addr = AW'(count - CNT_W'(1));
  assign full         = count == CNT_W'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CNT_W'(ALMOST_FULL);
  assign almost_empty = count <= CNT_W'(ALMOST_EMPTY);
  assign top          = empty ? '0 : rd;
  // swap overwrites the entry it reads; the async read still sees the old word
  lifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (do_push | do_swap),
    .waddr (do_swap ? top_addr : AW'(count)),
    .raddr (top_addr),
    .wdata (data_in),
    .rdata (rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count      <= do_push ? count + CNT_W'(1) : do_pop ? count - CNT_W'(1) : count;
      data_out   <= (do_pop | do_swap) ? rd : bypass ? data_in : data_out;
      data_valid <= do_pop | do_swap | bypass;
      overflow   <= ovf_set | (overflow & ~err_clr);
      underflow  <= unf_set | (underflow & ~err_clr);
    end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: vector table plus reference-model scoreboard for lifo_stack
module tb_lifo_stack;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1, write_en = 1'b0, read_en = 1'b0, err_clr = 1'b0;
  logic [7:0] data_in = '0, data_out, top;
  logic [4:0] count;
  logic data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  always #5 clk = ~clk;
  lifo_stack dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .data_in(data_in),
    .err_clr(err_clr), .data_out(data_out), .data_valid(data_valid), .top(top),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );
  int n_vec = 0, n_err = 0;
  logic [7:0] m [D];
  int mcnt = 0;
  logic mov = 1'b0, mun = 1'b0;
  logic [7:0] exp_q [$];
  typedef struct {
    logic we, re, clr;
    logic [7:0] din;
    int cnt;
    logic [7:0] tp;
    logic un;
  } vec_t;
  vec_t tbl [17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic we, input logic re, input logic [7:0] din, input logic clr);
    logic ov_set, un_set;
    ov_set = 1'b0;
    un_set = 1'b0;
    write_en = we; read_en = re; data_in = din; err_clr = clr;
    if (we && re) begin
      if (mcnt == 0) exp_q.push_back(din);
      else begin
        exp_q.push_back(m[mcnt-1]);
        m[mcnt-1] = din;
      end
    end else if (we) begin
      if (mcnt == D) ov_set = 1'b1;
      else begin
        m[mcnt] = din;
        mcnt++;
      end
    end else if (re) begin
      if (mcnt == 0) un_set = 1'b1;
      else begin
        mcnt--;
        exp_q.push_back(m[mcnt]);
      end
    end
    mov = ov_set | (mov & ~clr);
    mun = un_set | (mun & ~clr);
    @(posedge clk);
    #1;
    write_en = 1'b0; read_en = 1'b0; err_clr = 1'b0;
    chk("count", count, mcnt);
    chk("top", top, mcnt > 0 ? m[mcnt-1] : 8'h00);
    chk("full", full, mcnt == D);
    chk("empty", empty, mcnt == 0);
    chk("almost_full", almost_full, mcnt >= D - 2);
    chk("almost_empty", almost_empty, mcnt <= 2);
    chk("overflow", overflow, mov);
    chk("underflow", underflow, mun);
    if (exp_q.size() > 0) begin
      chk("data_valid", data_valid, 1);
      chk("data_out", data_out, exp_q.pop_front());
    end else chk("data_valid", data_valid, 0);
  endtask
  initial begin
    for (int i = 0; i < 7; i++) begin
      tbl[i] = '{1'b1, 1'b0, 1'b0, 8'(35 - 5*i), i + 1, 8'(35 - 5*i), 1'b0};
      tbl[7+i] = '{1'b0, 1'b1, 1'b0, 8'h00, 6 - i, (i < 6) ? 8'(10 + 5*i) : 8'h00, 1'b0};
    end
    tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h5A, 0, 8'h00, 1'b0};
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_top", top, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_ov", overflow, 0);
    chk("rst_un", underflow, 0);
    #10 rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din, tbl[i].clr);
      chk("tbl_count", count, tbl[i].cnt);
      chk("tbl_top", top, tbl[i].tp);
      chk("tbl_underflow", underflow, tbl[i].un);
    end
    chk("bypass_out", data_out, 8'h5A);
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, 8'(i + 1), 1'b0);
      if (i == 12) chk("af_at_13", almost_full, 0);
      if (i == 13) chk("af_at_14", almost_full, 1);
    end
    chk("fill_full", full, 1);
    step(1'b1, 1'b0, 8'hFF, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_top", top, 8'h10);
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    chk("swap_out", data_out, 8'h10);
    chk("swap_dv", data_valid, 1);
    chk("swap_top", top, 8'hAA);
    chk("swap_ov", overflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ov", overflow, 0);
    step(1'b1, 1'b0, 8'h77, 1'b1);
    chk("clr_set_wins", overflow, 1);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_rst_count", count, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", data_out, 0);
    mcnt = 0; mov = 1'b0; mun = 1'b0;
    exp_q.delete();
    #1 rst = 1'b0;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("post_rst_un", underflow, 1);
    chk("post_rst_dv", data_valid, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
